// File: rtl/op_stream_bridge.sv
// Buffered bridge between leaf_interface streams and an HLS operator's ap_hs ports.
// Every channel has its own FIFO, and an IDLE/RUN/DRAIN FSM sequences the operator's ap_start.

module op_stream_bridge_fifo #(
    parameter int W   = 32,
    parameter int DL2 = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] wr_data,
    input  logic         wr_vld,
    output logic         wr_ack,
    output logic [W-1:0] rd_data,
    output logic         rd_vld,
    input  logic         rd_ack
);
    localparam int DEPTH = 1 << DL2;

    logic [W-1:0] mem [DEPTH];
    logic [DL2:0] wr_ptr, rd_ptr;
    logic         full, empty, push, pop;

    // The pointers carry one extra wrap bit, so full and empty differ only in the MSB compare.
    assign full  = (wr_ptr[DL2] != rd_ptr[DL2]) && (wr_ptr[DL2-1:0] == rd_ptr[DL2-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ack  = ~full;
    assign rd_vld  = ~empty;
    assign rd_data = mem[rd_ptr[DL2-1:0]];
    assign push    = wr_vld & ~full;
    assign pop     = rd_ack & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DL2-1:0]] <= wr_data;
    end
endmodule

module op_stream_bridge #(
    parameter int NUM_IN       = 1,
    parameter int NUM_OUT      = 1,
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ap_start,
    input  logic [NUM_IN*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    input  logic [NUM_IN-1:0]               vld_interface2user,
    output logic [NUM_IN-1:0]               ack_user2interface,
    output logic [NUM_IN*PAYLOAD_BITS-1:0]  op_in_data,
    output logic [NUM_IN-1:0]               op_in_vld,
    input  logic [NUM_IN-1:0]               op_in_ack,
    input  logic [NUM_OUT*PAYLOAD_BITS-1:0] op_out_data,
    input  logic [NUM_OUT-1:0]              op_out_vld,
    output logic [NUM_OUT-1:0]              op_out_ack,
    output logic [NUM_OUT*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT-1:0]              vld_user2interface,
    input  logic [NUM_OUT-1:0]              ack_interface2user,
    output logic                            op_ap_start,
    input  logic                            op_ap_idle,
    output logic                            busy,
    output logic [31:0]                     in_words,
    output logic [31:0]                     out_words
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] in_inc, out_inc;
    logic        fifos_empty;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        op_stream_bridge_fifo #(.W(PAYLOAD_BITS), .DL2(DEPTH_LOG2)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_data (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_vld  (vld_interface2user[i]),
            .wr_ack  (ack_user2interface[i]),
            .rd_data (op_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_vld  (op_in_vld[i]),
            .rd_ack  (op_in_ack[i])
        );
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        op_stream_bridge_fifo #(.W(PAYLOAD_BITS), .DL2(DEPTH_LOG2)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_data (op_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_vld  (op_out_vld[j]),
            .wr_ack  (op_out_ack[j]),
            .rd_data (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_vld  (vld_user2interface[j]),
            .rd_ack  (ack_interface2user[j])
        );
    end

    assign fifos_empty = ~(|op_in_vld) & ~(|vld_user2interface);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_start) state_nxt = RUN;
            RUN:     if (!ap_start) state_nxt = DRAIN;
            DRAIN:   if (ap_start) state_nxt = RUN;
                     else if (fifos_empty && op_ap_idle) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_ap_start = (state == RUN);
        busy        = (state != IDLE);
    end

    // Count completed handshakes across all channels on each side.
    always_comb begin
        in_inc = '0;
        for (int i = 0; i < NUM_IN; i++)
            in_inc += 32'(vld_interface2user[i] & ack_user2interface[i]);
        out_inc = '0;
        for (int j = 0; j < NUM_OUT; j++)
            out_inc += 32'(vld_user2interface[j] & ack_interface2user[j]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_words  <= '0;
            out_words <= '0;
        end else begin
            in_words  <= in_words + in_inc;
            out_words <= out_words + out_inc;
        end
    end
endmodule

// File: tb/tb_op_stream_bridge.sv
// Scoreboard bench for op_stream_bridge: the stimulus queues the expected words, and
// per-side monitors pop and compare them at every handshake.

module tb_op_stream_bridge;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int W  = 32;
    localparam int NW = 1000;

    logic            clk, reset, ap_start, op_ap_idle, op_ap_start, busy;
    logic [NI*W-1:0] dout_leaf, op_in_data;
    logic [NI-1:0]   vld_i2u, ack_u2i, op_in_vld, op_in_ack;
    logic [NO*W-1:0] op_out_data, din_leaf;
    logic [NO-1:0]   op_out_vld, op_out_ack, vld_u2i, ack_i2u;
    logic [31:0]     in_words, out_words;

    logic            loop_en;
    logic [NI-1:0]   dir_in_ack;
    logic [NO-1:0]   dir_out_vld, dir_leaf_ack, gate, rnd_leaf_ack;
    logic [NO*W-1:0] dir_out_data;

    logic [31:0] in_q  [NI][$];
    logic [31:0] out_q [NO][$];
    int nchecks = 0;
    int nerr = 0;

    op_stream_bridge #(.NUM_IN(NI), .NUM_OUT(NO), .PAYLOAD_BITS(W), .DEPTH_LOG2(2)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .dout_leaf_interface2user(dout_leaf), .vld_interface2user(vld_i2u),
        .ack_user2interface(ack_u2i),
        .op_in_data(op_in_data), .op_in_vld(op_in_vld), .op_in_ack(op_in_ack),
        .op_out_data(op_out_data), .op_out_vld(op_out_vld), .op_out_ack(op_out_ack),
        .din_leaf_user2interface(din_leaf), .vld_user2interface(vld_u2i),
        .ack_interface2user(ack_i2u),
        .op_ap_start(op_ap_start), .op_ap_idle(op_ap_idle), .busy(busy),
        .in_words(in_words), .out_words(out_words)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // In loopback mode a model operator forwards each input channel to the matching output channel.
    always_comb begin
        if (loop_en) begin
            op_in_ack   = op_out_ack & gate;
            op_out_vld  = op_in_vld & gate;
            op_out_data = op_in_data;
            ack_i2u     = rnd_leaf_ack;
        end else begin
            op_in_ack   = dir_in_ack;
            op_out_vld  = dir_out_vld;
            op_out_data = dir_out_data;
            ack_i2u     = dir_leaf_ack;
        end
    end

    initial begin
        gate = '0;
        rnd_leaf_ack = '0;
        forever begin
            @(posedge clk); #1;
            gate         = NO'($urandom);
            rnd_leaf_ack = NO'($urandom);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                if (op_in_vld[i] && op_in_ack[i]) begin
                    if (in_q[i].size() == 0) chk("in_unexpected", op_in_data[i*W +: W], 32'hdead);
                    else chk("in_data", op_in_data[i*W +: W], in_q[i].pop_front());
                end
            for (int j = 0; j < NO; j++)
                if (vld_u2i[j] && ack_i2u[j]) begin
                    if (out_q[j].size() == 0) chk("out_unexpected", din_leaf[j*W +: W], 32'hdead);
                    else chk("out_data", din_leaf[j*W +: W], out_q[j].pop_front());
                end
        end
    end

    initial begin
        int idx [NI];
        logic [NI-1:0] sacc;
        int cyc;
        reset = 1; ap_start = 0; op_ap_idle = 0; vld_i2u = '0; dout_leaf = '0;
        dir_in_ack = '0; dir_out_vld = '0; dir_out_data = '0; dir_leaf_ack = '0; loop_en = 0;
        step; step;
        reset = 0;
        chk("rst_ack", 32'(ack_u2i), 32'h3);
        chk("rst_op_out_ack", 32'(op_out_ack), 32'h3);
        chk("rst_op_in_vld", 32'(op_in_vld), 32'h0);
        chk("rst_leaf_vld", 32'(vld_u2i), 32'h0);
        chk("rst_start_busy", {30'd0, op_ap_start, busy}, 32'h0);
        chk("rst_in_words", in_words, 32'h0);
        chk("rst_out_words", out_words, 32'h0);

        // Fill channel 0 to capacity while the operator refuses.
        vld_i2u = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            dout_leaf[31:0] = 32'h11 * k;
            in_q[0].push_back(32'h11 * k);
            step;
        end
        chk("full_ack", 32'(ack_u2i[0]), 32'h0);
        chk("full_vld", 32'(op_in_vld[0]), 32'h1);
        dout_leaf[31:0] = 32'h55;
        step;
        chk("refused_ack", 32'(ack_u2i[0]), 32'h0);
        chk("refused_words", in_words, 32'h4);
        // Pop while full: this push is refused and the word is taken one cycle later.
        dir_in_ack = 2'b01;
        step;
        chk("pop_full_ack", 32'(ack_u2i[0]), 32'h1);
        chk("pop_full_words", in_words, 32'h4);
        in_q[0].push_back(32'h55);
        step;
        chk("retry_words", in_words, 32'h5);
        vld_i2u = '0;
        step; step;
        chk("drain_vld_hi", 32'(op_in_vld[0]), 32'h1);
        step;
        chk("drain_vld_lo", 32'(op_in_vld[0]), 32'h0);
        chk("drain_q", 32'(in_q[0].size()), 32'h0);
        dir_in_ack = '0;

        // Output side, channel 1.
        dir_out_vld = 2'b10;
        dir_out_data[63:32] = 32'hA1; out_q[1].push_back(32'hA1); step;
        dir_out_data[63:32] = 32'hA2; out_q[1].push_back(32'hA2); step;
        dir_out_vld = '0;
        chk("out_vld", 32'(vld_u2i), 32'h2);
        chk("out_words0", out_words, 32'h0);
        dir_leaf_ack = 2'b10;
        step; step;
        chk("out_vld_lo", 32'(vld_u2i), 32'h0);
        chk("out_words2", out_words, 32'h2);
        chk("in_words_hold", in_words, 32'h5);
        dir_leaf_ack = '0;

        // FSM: prefill 3 words, run for 10 cycles, then drain.
        vld_i2u = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            dout_leaf[31:0] = 32'hB0 + k;
            in_q[0].push_back(32'hB0 + k);
            step;
        end
        vld_i2u = '0;
        chk("idle_start", 32'(op_ap_start), 32'h0);
        ap_start = 1;
        for (int k = 0; k < 10; k++) begin
            step;
            chk("run_start", 32'(op_ap_start), 32'h1);
        end
        ap_start = 0;
        step;
        chk("drain_start", 32'(op_ap_start), 32'h0);
        chk("drain_busy", 32'(busy), 32'h1);
        step; step; step;
        chk("drain_busy_q", 32'(busy), 32'h1);
        dir_in_ack = 2'b01;
        step; step; step;
        chk("drain_empty", 32'(op_in_vld), 32'h0);
        chk("drain_busy_idle0", 32'(busy), 32'h1);
        dir_in_ack = '0;
        ap_start = 1;
        step;
        chk("rearm_start", 32'(op_ap_start), 32'h1);
        ap_start = 0; op_ap_idle = 1;
        step;
        chk("drain2_busy", 32'(busy), 32'h1);
        chk("drain2_start", 32'(op_ap_start), 32'h0);
        step;
        chk("idle_busy", 32'(busy), 32'h0);

        // Reset with words queued while running; they must be discarded.
        ap_start = 1;
        step;
        vld_i2u = 2'b10;
        dout_leaf[63:32] = 32'hC1; step;
        dout_leaf[63:32] = 32'hC2; step;
        vld_i2u = '0;
        chk("pre_rst_vld", 32'(op_in_vld), 32'h2);
        chk("pre_rst_start", 32'(op_ap_start), 32'h1);
        reset = 1; ap_start = 0;
        step;
        reset = 0;
        chk("mid_rst_vld", 32'(op_in_vld), 32'h0);
        chk("mid_rst_start_busy", {30'd0, op_ap_start, busy}, 32'h0);
        chk("mid_rst_in_words", in_words, 32'h0);
        chk("mid_rst_out_words", out_words, 32'h0);
        chk("mid_rst_ack", 32'(ack_u2i), 32'h3);
        dir_in_ack = 2'b11;
        step; step; step; step;
        chk("mid_rst_no_old", 32'(op_in_vld), 32'h0);
        dir_in_ack = '0;

        // Random-handshake loopback on both channels.
        reset = 1;
        step;
        reset = 0;
        loop_en = 1;
        idx[0] = 0; idx[1] = 0; sacc = '0; cyc = 0;
        while ((idx[0] < NW || idx[1] < NW) && cyc < 20000) begin
            for (int c = 0; c < NI; c++) begin
                if (vld_i2u[c] && sacc[c]) begin
                    idx[c]++;
                    vld_i2u[c] = 1'b0;
                end
                if (!vld_i2u[c] && idx[c] < NW && $urandom_range(0, 3) != 0) begin
                    dout_leaf[c*W +: W] = 32'h1000_0000 * (c + 1) + idx[c];
                    in_q[c].push_back(32'h1000_0000 * (c + 1) + idx[c]);
                    out_q[c].push_back(32'h1000_0000 * (c + 1) + idx[c]);
                    vld_i2u[c] = 1'b1;
                end
            end
            sacc = ack_u2i;
            step;
            cyc++;
        end
        vld_i2u = '0;
        chk("loop_sent", 32'(idx[0] + idx[1]), 32'(2 * NW));
        cyc = 0;
        while ((in_q[0].size() + in_q[1].size() + out_q[0].size() + out_q[1].size()) != 0
               && cyc < 2000) begin
            step;
            cyc++;
        end
        step;
        chk("loop_q_empty",
            32'(in_q[0].size() + in_q[1].size() + out_q[0].size() + out_q[1].size()), 32'h0);
        chk("loop_in_words", in_words, 32'(2 * NW));
        chk("loop_out_words", out_words, 32'(2 * NW));
        loop_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
